// File: rtl/cpu_boot_loader.sv
// Byte-serial image loader: header, code words (high byte first), data bytes, checksum.
// All outputs registered; one byte per cycle when rx_valid is held, CPU released only on a good checksum.
module cpu_boot_loader #(
  parameter int CODE_BASE  = 32,
  parameter int CMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 16,
  localparam int CA_W = $clog2(CMEM_DEPTH),
  localparam int DA_W = $clog2(DMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            cmem_we,
  output logic [CA_W-1:0] cmem_addr,
  output logic [15:0]     cmem_wdata,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  output logic [7:0]      dmem_wdata,
  output logic            cpu_reset,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [3:0] {
    IDLE,
    HDR_CODE,
    HDR_DATA,
    CODE_HI,
    CODE_LO,
    DATA,
    CHECK,
    RUN,
    ERROR
  } state_t;

  localparam logic [CA_W-1:0] BASE_ADDR = CA_W'(CODE_BASE);
  localparam logic [CA_W:0]   WORD_ONE  = 1;
  localparam logic [DA_W:0]   BYTE_ONE  = 1;

  state_t          state, state_d;
  logic [CA_W:0]   n_code, n_code_d;
  logic [DA_W:0]   n_data, n_data_d;
  logic [CA_W:0]   word_idx, word_idx_d;
  logic [DA_W:0]   byte_idx, byte_idx_d;
  logic [7:0]      hi_byte, hi_byte_d;
  logic [7:0]      sum, sum_d;

  logic            rx_ready_d;
  logic            cmem_we_d;
  logic [CA_W-1:0] cmem_addr_d;
  logic [15:0]     cmem_wdata_d;
  logic            dmem_we_d;
  logic [DA_W-1:0] dmem_addr_d;
  logic [7:0]      dmem_wdata_d;
  logic            cpu_reset_d;
  logic            busy_d;
  logic            done_d;
  logic            err_d;

  logic            accept;

  // rx_ready is registered from the state, so it always reflects the current state.
  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_d      = state;
    n_code_d     = n_code;
    n_data_d     = n_data;
    word_idx_d   = word_idx;
    byte_idx_d   = byte_idx;
    hi_byte_d    = hi_byte;
    sum_d        = sum;
    cmem_we_d    = 1'b0;
    cmem_addr_d  = cmem_addr;
    cmem_wdata_d = cmem_wdata;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    cpu_reset_d  = cpu_reset;
    busy_d       = busy;
    done_d       = done;
    err_d        = err;

    case (state)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d     = HDR_CODE;
          sum_d       = 8'd0;
          word_idx_d  = '0;
          byte_idx_d  = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end

      HDR_CODE: begin
        if (accept) begin
          sum_d = sum + rx_data;
          if (rx_data == 8'd0 || rx_data > 8'(CMEM_DEPTH)) begin
            state_d = ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            n_code_d = rx_data[CA_W:0];
            state_d  = HDR_DATA;
          end
        end
      end

      HDR_DATA: begin
        if (accept) begin
          sum_d = sum + rx_data;
          if (rx_data > 8'(DMEM_DEPTH)) begin
            state_d = ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            n_data_d = rx_data[DA_W:0];
            state_d  = CODE_HI;
          end
        end
      end

      CODE_HI: begin
        if (accept) begin
          sum_d     = sum + rx_data;
          hi_byte_d = rx_data;
          state_d   = CODE_LO;
        end
      end

      CODE_LO: begin
        if (accept) begin
          sum_d        = sum + rx_data;
          cmem_we_d    = 1'b1;
          // Address arithmetic is modulo the memory depth, so the image may wrap past the top.
          cmem_addr_d  = BASE_ADDR + word_idx[CA_W-1:0];
          cmem_wdata_d = {hi_byte, rx_data};
          word_idx_d   = word_idx + WORD_ONE;
          if ((word_idx + WORD_ONE) == n_code) begin
            state_d = (n_data != '0) ? DATA : CHECK;
          end else begin
            state_d = CODE_HI;
          end
        end
      end

      DATA: begin
        if (accept) begin
          sum_d        = sum + rx_data;
          dmem_we_d    = 1'b1;
          dmem_addr_d  = byte_idx[DA_W-1:0];
          dmem_wdata_d = rx_data;
          byte_idx_d   = byte_idx + BYTE_ONE;
          if ((byte_idx + BYTE_ONE) == n_data) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (rx_data == sum) begin
            state_d     = RUN;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rx_ready_d = (state_d != IDLE) && (state_d != RUN) && (state_d != ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n_code     <= '0;
      n_data     <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      hi_byte    <= 8'd0;
      sum        <= 8'd0;
      rx_ready   <= 1'b0;
      cmem_we    <= 1'b0;
      cmem_addr  <= '0;
      cmem_wdata <= 16'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 8'd0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      n_code     <= n_code_d;
      n_data     <= n_data_d;
      word_idx   <= word_idx_d;
      byte_idx   <= byte_idx_d;
      hi_byte    <= hi_byte_d;
      sum        <= sum_d;
      rx_ready   <= rx_ready_d;
      cmem_we    <= cmem_we_d;
      cmem_addr  <= cmem_addr_d;
      cmem_wdata <= cmem_wdata_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      cpu_reset  <= cpu_reset_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: doc/cpu_boot_loader.md
# cpu_boot_loader

Byte-serial program loader sitting directly upstream of the toy CPU's code and data memories. It receives a framed image from a host over a valid/ready byte stream and assembles 16-bit instruction words. It writes them into code memory starting at a fixed base address, then writes data bytes into data memory. After verifying a checksum, it releases the CPU core from reset.

## Interface
- CODE_BASE, 32: code-memory address of the first loaded instruction word.
- CMEM_DEPTH, 64: code-memory words; address width 6.
- DMEM_DEPTH, 16: data-memory bytes; address width 4.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a load session; sampled only in IDLE, RUN or ERROR.
- rx_data  in  8  host byte.
- rx_valid  in  1  host byte valid.
- rx_ready  out  1  loader accepts the byte.
- cmem_we  out  1  code-memory write strobe, one cycle per word.
- cmem_addr  out  6  code-memory write address.
- cmem_wdata  out  16  instruction word.
- dmem_we  out  1  data-memory write strobe, one cycle per byte.
- dmem_addr  out  4  data-memory write address.
- dmem_wdata  out  8  data byte.
- cpu_reset  out  1  drives the CPU's reset; high whenever the image is not verified.
- busy  out  1  session in progress.
- done  out  1  image verified; CPU running.
- err  out  1  header or checksum failure.

## Operation
- Frame, in order: N_CODE (1..64), N_DATA (0..16), N_CODE words sent high byte first, N_DATA data bytes, CHK.
- CHK must equal the 8-bit sum, mod 256, of every byte from N_CODE through the last data byte.
- A byte transfer occurs on a rising edge when rx_valid && rx_ready.
- FSM states: IDLE, HDR_CODE, HDR_DATA, CODE_HI, CODE_LO, DATA, CHECK, RUN, ERROR.
- IDLE, RUN or ERROR + start: go to HDR_CODE; clear the running sum and word/byte indices; set busy=1, done=0, err=0, cpu_reset=1.
- HDR_CODE: accept N_CODE.
  - 0 or >64: go to ERROR.
  - Otherwise go to HDR_DATA.
- HDR_DATA: accept N_DATA.
  - >16: go to ERROR.
  - Otherwise go to CODE_HI.
- CODE_HI: latch the high byte, then go to CODE_LO.
- CODE_LO: on accept, register the write:
  - cmem_wdata = {hi, lo}.
  - cmem_addr = (CODE_BASE + word_index) mod 64. Wrap-around is legal: base 32 with 40 words writes 32..63, then 0..7.
  - Pulse cmem_we.
  - Increment word_index.
  - If the last word was written: go to DATA if N_DATA>0, else CHECK. Otherwise go to CODE_HI.
- DATA: on accept, register the write:
  - dmem_wdata = byte, dmem_addr = byte_index (starting at 0), pulse dmem_we.
  - After the last byte, go to CHECK.
- CHECK: accept CHK.
  - Match: go to RUN with done=1, busy=0, cpu_reset=0.
  - Mismatch: go to ERROR with err=1, busy=0, cpu_reset stays 1.
- ERROR: the memory contents already written are left as-is; only start exits this state.
- rx_ready=1 in HDR_CODE through CHECK, 0 in all other states. A start asserted during a session is ignored.
- The running sum includes only accepted bytes; CHK itself is excluded.

## Timing
- Reset values: rx_ready=0, cmem_we=0, cmem_addr=0, cmem_wdata=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, cpu_reset=1, busy=0, done=0, err=0. FSM state is IDLE.
- All outputs are registered.
- start sampled at edge T gives busy=1 and rx_ready=1 after T.
- A write strobe is high for exactly the one cycle following the edge that accepted the completing byte. Address and data are valid in that same cycle.
- Back-to-back bytes are accepted at full rate, one per cycle; stalls in rx_valid insert idle cycles with no writes.
- done, err and cpu_reset update in the cycle after the edge that accepted CHK or the bad header byte.
- Minimum frame length is 2 + 2·N_CODE + N_DATA + 1 cycles at full rate.
- Reset mid-session: on the next edge all outputs return to reset values and cpu_reset=1; no partial write strobe is issued after reset.
- If reset and start are asserted together, reset wins.

## Test plan
- Full image: N_CODE=20, N_DATA=9, the 20-word program and DMEM values 7,3,2,1,6,4,5,8,7, correct CHK.
  - Required: 20 cmem_we pulses at addresses 32..51 with the matching words, 9 dmem_we pulses at addresses 0..8.
  - Required: done=1 and cpu_reset=0 one cycle after CHK.
- Wrap: N_CODE=40, N_DATA=0 -> cmem_addr sequence 32..63 then 0..7, no dmem_we, done=1.
- Bad CHK: the first image with CHK+1 -> all writes still occur; err=1, done=0, cpu_reset=1. A subsequent start plus the good frame then reaches done=1.
- Header errors: N_CODE=0 -> err=1 with no further rx_ready. N_CODE=1, N_DATA=17 -> err=1 and no cmem_we.
- Throttled host: rx_valid toggled randomly -> writes identical to the first scenario; no byte is lost or duplicated; start pulses mid-session are ignored.
- Reset mid-load after the 5th word -> outputs at reset values next cycle, no further strobes; a restarted full frame completes correctly.
